// File: rtl/pc_redirect_unit.sv
// pc_redirect_unit: IF-stage PC with flush/branch redirect, stall-buffered branch target and alignment check
module pc_redirect_unit #(
  parameter int unsigned ADDR_W = 32,
  parameter logic [ADDR_W-1:0] RESET_PC = '0,
  parameter int unsigned STEP = 4,
  parameter int unsigned ALIGN_BITS = 2
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              pc_stall,
  input  logic              if_branch,
  input  logic [ADDR_W-1:0] target_pc,
  input  logic              flush,
  input  logic [ADDR_W-1:0] flush_pc,
  output logic [ADDR_W-1:0] pc,
  output logic              ce,
  output logic              redirect_pending,
  output logic              addr_misalign
);
  localparam logic [ADDR_W-1:0] HI_MASK = {ADDR_W{1'b1}} << ALIGN_BITS;
  localparam logic [ADDR_W-1:0] STEP_W = ADDR_W'(STEP);
  logic [ADDR_W-1:0] pend_pc, ld_pc, ld_al, pc_n, pend_pc_n;
  logic              pend_n, mis_n, capture;
  always_comb begin
    ld_pc     = flush ? flush_pc : target_pc;
    ld_al     = ld_pc & HI_MASK;
    mis_n     = (flush | if_branch) & |(ld_pc & ~HI_MASK);
    capture   = !flush && pc_stall && if_branch;
    pc_n      = flush ? ld_al : pc_stall ? pc : if_branch ? ld_al : redirect_pending ? pend_pc : pc + STEP_W;
    pend_n    = !flush && pc_stall && (if_branch || redirect_pending);
    pend_pc_n = capture ? ld_al : pend_pc;
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      ce               <= 1'b0;
      pc               <= RESET_PC;
      redirect_pending <= 1'b0;
      pend_pc          <= '0;
      addr_misalign    <= 1'b0;
    end else if (!ce) begin
      ce               <= 1'b1;
      pc               <= RESET_PC;
      redirect_pending <= 1'b0;
      addr_misalign    <= 1'b0;
    end else begin
      pc               <= pc_n;
      redirect_pending <= pend_n;
      pend_pc          <= pend_pc_n;
      addr_misalign    <= mis_n;
    end
  end
endmodule

// File: tb/tb_pc_redirect_unit.sv
// tb_pc_redirect_unit: directed scoreboard bench for pc_redirect_unit
module tb_pc_redirect_unit;
  logic        clk = 0, rst = 1, pc_stall = 0, if_branch = 0, flush = 0;
  logic [31:0] target_pc = '0, flush_pc = '0, pc;
  logic        ce, redirect_pending, addr_misalign;
  logic [34:0] sb[$];
  int          tests = 0, fails = 0;
  pc_redirect_unit dut (
    .clk(clk), .rst(rst), .pc_stall(pc_stall), .if_branch(if_branch), .target_pc(target_pc),
    .flush(flush), .flush_pc(flush_pc), .pc(pc), .ce(ce),
    .redirect_pending(redirect_pending), .addr_misalign(addr_misalign)
  );
  always #5 clk = ~clk;
  task automatic check(input string tag);
    logic [34:0] got, exp;
    got = {pc, ce, redirect_pending, addr_misalign};
    exp = sb.pop_front();
    tests++;
    assert (got === exp) else begin
      fails++;
      $error("FAIL %s: got pc=%h ce=%b pend=%b mis=%b, want pc=%h ce=%b pend=%b mis=%b",
             tag, got[34:3], got[2], got[1], got[0], exp[34:3], exp[2], exp[1], exp[0]);
    end
  endtask
  task automatic cyc(input string tag, input logic r, st, br, input logic [31:0] tgt,
                     input logic fl, input logic [31:0] fpc,
                     input logic [31:0] e_pc, input logic e_ce, e_pend, e_mis);
    rst = r; pc_stall = st; if_branch = br; target_pc = tgt; flush = fl; flush_pc = fpc;
    sb.push_back({e_pc, e_ce, e_pend, e_mis});
    @(posedge clk);
    #1;
    check(tag);
  endtask
  initial begin
    #1;
    for (int i = 0; i < 3; i++) cyc("reset", 1, 0, 0, 0, 0, 0, 32'h0, 0, 0, 0);
    rst = 0;
    sb.push_back({32'h0, 1'b0, 1'b0, 1'b0});
    #1;
    check("ce_low_after_release");
    cyc("boot0", 0, 0, 0, 0, 0, 0, 32'h0, 1, 0, 0);
    cyc("boot4", 0, 0, 0, 0, 0, 0, 32'h4, 1, 0, 0);
    cyc("boot8", 0, 0, 0, 0, 0, 0, 32'h8, 1, 0, 0);
    cyc("bootC", 0, 0, 0, 0, 0, 0, 32'hC, 1, 0, 0);
    cyc("seq10", 0, 0, 0, 0, 0, 0, 32'h10, 1, 0, 0);
    cyc("stall_br", 0, 1, 1, 32'h100, 0, 0, 32'h10, 1, 1, 0);
    cyc("stall2", 0, 1, 0, 0, 0, 0, 32'h10, 1, 1, 0);
    cyc("stall3", 0, 1, 0, 0, 0, 0, 32'h10, 1, 1, 0);
    cyc("release", 0, 0, 0, 0, 0, 0, 32'h100, 1, 0, 0);
    cyc("after_rel", 0, 0, 0, 0, 0, 0, 32'h104, 1, 0, 0);
    cyc("buf100a", 0, 1, 1, 32'h100, 0, 0, 32'h104, 1, 1, 0);
    cyc("live_beats_pend", 0, 0, 1, 32'h200, 0, 0, 32'h200, 1, 0, 0);
    cyc("pend_dropped", 0, 0, 0, 0, 0, 0, 32'h204, 1, 0, 0);
    cyc("buf100b", 0, 1, 1, 32'h100, 0, 0, 32'h204, 1, 1, 0);
    cyc("flush_wins", 0, 0, 1, 32'h200, 1, 32'h80, 32'h80, 1, 0, 0);
    cyc("after_flush", 0, 0, 0, 0, 0, 0, 32'h84, 1, 0, 0);
    cyc("flush_stall", 0, 1, 0, 0, 1, 32'h180, 32'h180, 1, 0, 0);
    cyc("after_fs", 0, 0, 0, 0, 0, 0, 32'h184, 1, 0, 0);
    cyc("mis_br", 0, 0, 1, 32'h103, 0, 0, 32'h100, 1, 0, 1);
    cyc("mis_off", 0, 0, 0, 0, 0, 0, 32'h104, 1, 0, 0);
    cyc("mis_capture", 0, 1, 1, 32'h207, 0, 0, 32'h104, 1, 1, 1);
    cyc("mis_hold", 0, 1, 0, 0, 0, 0, 32'h104, 1, 1, 0);
    cyc("mis_release", 0, 0, 0, 0, 0, 0, 32'h204, 1, 0, 0);
    cyc("mis_flush", 0, 0, 0, 0, 1, 32'h2A1, 32'h2A0, 1, 0, 1);
    cyc("to_top", 0, 0, 1, 32'hFFFF_FFFC, 0, 0, 32'hFFFF_FFFC, 1, 0, 0);
    cyc("wrap", 0, 0, 0, 0, 0, 0, 32'h0, 1, 0, 0);
    cyc("post_wrap", 0, 0, 0, 0, 0, 0, 32'h4, 1, 0, 0);
    cyc("buf300", 0, 1, 1, 32'h300, 0, 0, 32'h4, 1, 1, 0);
    cyc("rst_mid", 1, 0, 0, 0, 0, 0, 32'h0, 0, 0, 0);
    cyc("flush_ce0", 0, 0, 0, 0, 1, 32'h80, 32'h0, 1, 0, 0);
    for (int i = 1; i <= 4; i++) cyc("reboot", 0, 0, 0, 0, 0, 0, 32'(4 * i), 1, 0, 0);
    if (sb.size() != 0) begin
      fails++;
      $display("FAIL scoreboard: %0d entries left, want 0", sb.size());
    end
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule

// File: doc/pc_redirect_unit.md
# pc_redirect_unit

Parametrised program-counter unit for the IF stage, successor to the fixed 32-bit PC register. Holds the fetch address and the instruction-ROM chip enable, and advances by a configurable step. Adds three things the single-step PC lacked: an exception/flush redirect with top priority, a one-entry pending-redirect buffer so a branch resolved during a stall is not lost, and target alignment checking. Sits between the ID/EX branch logic, the pipeline control (stall/flush) unit and the instruction ROM.

## Interface
- ADDR_W, 32, width of the PC and all target buses
- RESET_PC, 0, PC value while the chip enable is low
- STEP, 4, sequential increment added to the PC per advance
- ALIGN_BITS, 2, number of low PC bits that must be zero

- clk  in  1  rising-edge clock
- rst  in  1  synchronous, active-high reset
- pc_stall  in  1  1 = hold the PC this cycle
- if_branch  in  1  1 = branch/jump taken; load target_pc
- target_pc  in  ADDR_W  branch target
- flush  in  1  1 = exception/flush redirect; load flush_pc
- flush_pc  in  ADDR_W  exception handler or flush target
- pc  out  ADDR_W  current fetch address (registered)
- ce  out  1  instruction-ROM chip enable (registered)
- redirect_pending  out  1  a buffered branch target is waiting (registered)
- addr_misalign  out  1  one-cycle pulse: the last loaded target had nonzero low bits (registered)

## Operation
- Reset (rst=1 at an edge): ce=0, pc=RESET_PC, redirect_pending=0, pending target register cleared, addr_misalign=0.
- ce: registered copy of ~rst. It is 0 in the first cycle after rst falls and 1 from the next edge.
- While ce=0: pc=RESET_PC. All other inputs are ignored and nothing is buffered.
- While ce=1, the PC update per edge follows this strict priority:
  1. flush=1: pc<=flush_pc. Pending is cleared. This happens even if pc_stall=1.
  2. pc_stall=1: pc holds. If if_branch=1, the pending register is loaded with target_pc and redirect_pending<=1. The newest branch overwrites an older pending one.
  3. if_branch=1: pc<=target_pc. Pending is cleared, so the live branch beats the buffered one.
  4. redirect_pending=1: pc<=pending target, then redirect_pending<=0.
  5. Otherwise: pc<=pc+STEP, modulo 2^ADDR_W. 0xFFFFFFFC+4 wraps to 0x00000000.
- Alignment applies to every target loaded from flush_pc, target_pc or the pending register:
  - Bits [ALIGN_BITS-1:0] are forced to 0 before the target is written to pc or to pending.
  - If any of those bits were nonzero, addr_misalign=1 for exactly the cycle after the load edge, otherwise 0.
  - A misaligned target captured under stall raises addr_misalign at capture, not at release.
- Sequential increments never raise addr_misalign.
- Width rule: all adds are ADDR_W bits and the carry is discarded. STEP is zero-extended to ADDR_W.

## Timing
- All outputs are registered. There is no combinational path from inputs to outputs.
- Redirect latency: a flush or an unstalled branch sampled at edge N appears on pc after edge N.
- A branch captured under stall appears on pc one edge after pc_stall is first sampled low, provided no new flush or branch arrives at that edge.
- Simultaneous events:
  - flush + if_branch: flush wins and the branch is discarded.
  - flush + pending: pending is discarded.
  - if_branch + pending with no stall: if_branch wins and pending is cleared.
- Reset mid-operation (rst=1 with ce=1 and pending set): at the next edge ce=0, pc=RESET_PC, and pending is cleared. The buffered target is never applied.
- flush asserted while ce=0 is ignored.

## Test plan
- Reset and boot with RESET_PC=0:
  - Hold rst 3 cycles, then release.
  - Required: ce=0 and pc=0 for the first edge after release.
  - Then ce=1, and pc reads 0, 4, 8, 0xC on successive edges.
- Branch during stall:
  - At pc=0x10, assert pc_stall for 3 cycles with if_branch=1, target_pc=0x100 pulsed in the first stall cycle.
  - Required: pc stays 0x10 and redirect_pending=1 during the stall.
  - On the first unstalled edge pc=0x100 and redirect_pending=0, then 0x104.
- Priority:
  - With pending=0x100 buffered, drop the stall and present if_branch=1, target_pc=0x200 at the same edge. Required: pc=0x200, pending cleared.
  - Repeat with flush=1, flush_pc=0x80 also asserted. Required: pc=0x80.
- Flush under stall: pc_stall=1, flush=1, flush_pc=0x180 -> pc=0x180 on the next edge regardless of the stall.
- Misalignment and wrap:
  - Unstalled target_pc=0x103 -> pc=0x100, with addr_misalign high for exactly one cycle.
  - Set pc to 0xFFFFFFFC, then let it run -> next pc=0x00000000 with no misalign pulse.
- Reset mid-pending: pending=0x300 buffered, then rst=1 for 1 cycle -> pc=RESET_PC, ce=0, redirect_pending=0. After boot, pc never takes the value 0x300.
